// File: rtl/emissor_snooping_if.sv
// rtl/emissor_snooping_if.sv - CPU, bus and snoop signal bundle for the MSI snooping transmitter
interface emissor_snooping_if #(
   parameter int INDEX_W = 2,
   parameter int TAG_W   = 4
);
   localparam int A = TAG_W + INDEX_W;

   logic         cpuValid;
   logic         cpuWrite;
   logic [A-1:0] cpuAddr;
   logic         cpuReady;
   logic         hit;
   logic         busReq;
   logic         busGrant;
   logic [2:0]   mensagemBus;
   logic [A-1:0] busAddr;
   logic         writeBack;
   logic         snoopValid;
   logic [2:0]   snoopMsg;
   logic [A-1:0] snoopAddr;
   logic [1:0]   estado;

   modport slave (
      input  cpuValid, cpuWrite, cpuAddr, busGrant, snoopValid, snoopMsg, snoopAddr,
      output cpuReady, hit, busReq, mensagemBus, busAddr, writeBack, estado
   );

   modport master (
      output cpuValid, cpuWrite, cpuAddr, busGrant, snoopValid, snoopMsg, snoopAddr,
      input  cpuReady, hit, busReq, mensagemBus, busAddr, writeBack, estado
   );
endinterface

// File: rtl/emissor_snooping.sv
// rtl/emissor_snooping.sv - MSI snooping transmitter: hit/miss classification and bus message issue
module emissor_snooping #(
   parameter int INDEX_W = 2,
   parameter int TAG_W   = 4
) (
   input  logic                clock,
   input  logic                reset,
   emissor_snooping_if.slave   bus
);
   localparam int A     = TAG_W + INDEX_W;
   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [2:0] {IDLE, EVAL, WB, REQ, DONE} fsm_t;
   typedef enum logic [1:0] {INVALID = 2'b00, SHARED = 2'b01, EXCLUSIVE = 2'b10} line_t;

   localparam logic [2:0] MSG_NONE = 3'b000;
   localparam logic [2:0] MSG_WM   = 3'b001;
   localparam logic [2:0] MSG_RM   = 3'b010;
   localparam logic [2:0] MSG_INV  = 3'b011;

   fsm_t             fsm_q, fsm_d;
   line_t            line_q [LINES];
   line_t            line_d [LINES];
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [TAG_W-1:0] tag_d  [LINES];

   logic             req_write_q, req_write_d;
   logic [A-1:0]     req_addr_q, req_addr_d;
   logic [2:0]       msg_q, msg_d;

   logic             cpu_ready_q, cpu_ready_d;
   logic             hit_q, hit_d;
   logic             bus_req_q, bus_req_d;
   logic [2:0]       msg_bus_q, msg_bus_d;
   logic [A-1:0]     bus_addr_q, bus_addr_d;
   logic             write_back_q, write_back_d;
   line_t            estado_q, estado_d;

   logic [INDEX_W-1:0] req_idx, snp_idx;
   logic [TAG_W-1:0]   req_tag, snp_tag;

   assign req_idx = req_addr_q[INDEX_W-1:0];
   assign req_tag = req_addr_q[A-1:INDEX_W];
   assign snp_idx = bus.snoopAddr[INDEX_W-1:0];
   assign snp_tag = bus.snoopAddr[A-1:INDEX_W];

   always_comb begin
      fsm_d        = fsm_q;
      line_d       = line_q;
      tag_d        = tag_q;
      req_write_d  = req_write_q;
      req_addr_d   = req_addr_q;
      msg_d        = msg_q;
      cpu_ready_d  = 1'b0;
      hit_d        = 1'b0;
      write_back_d = 1'b0;
      bus_req_d    = bus_req_q;
      msg_bus_d    = msg_bus_q;
      bus_addr_d   = bus_addr_q;

      // Snoops land first so the FSM below always decides on post-snoop line state.
      if (bus.snoopValid && !bus.busGrant &&
          line_q[snp_idx] != INVALID && tag_q[snp_idx] == snp_tag) begin
         case (bus.snoopMsg)
            MSG_WM, MSG_INV: line_d[snp_idx] = INVALID;
            MSG_RM: if (line_q[snp_idx] == EXCLUSIVE) line_d[snp_idx] = SHARED;
            default: ;
         endcase
      end

      case (fsm_q)
         IDLE: begin
            if (bus.cpuValid) begin
               req_write_d = bus.cpuWrite;
               req_addr_d  = bus.cpuAddr;
               fsm_d       = EVAL;
            end
         end
         EVAL: begin
            if (line_d[req_idx] != INVALID && tag_q[req_idx] == req_tag) begin
               if (!req_write_q || line_d[req_idx] == EXCLUSIVE) begin
                  fsm_d       = DONE;
                  cpu_ready_d = 1'b1;
                  hit_d       = 1'b1;
               end else begin
                  msg_d      = MSG_INV;
                  fsm_d      = REQ;
                  bus_req_d  = 1'b1;
                  msg_bus_d  = MSG_INV;
                  bus_addr_d = req_addr_q;
               end
            end else begin
               msg_d = req_write_q ? MSG_WM : MSG_RM;
               if (line_d[req_idx] == EXCLUSIVE) begin
                  fsm_d        = WB;
                  write_back_d = 1'b1;
                  bus_addr_d   = {tag_q[req_idx], req_idx};
               end else begin
                  fsm_d      = REQ;
                  bus_req_d  = 1'b1;
                  msg_bus_d  = req_write_q ? MSG_WM : MSG_RM;
                  bus_addr_d = req_addr_q;
               end
            end
         end
         WB: begin
            line_d[req_idx] = INVALID;
            fsm_d           = REQ;
            bus_req_d       = 1'b1;
            msg_bus_d       = msg_q;
            bus_addr_d      = req_addr_q;
         end
         REQ: begin
            if (bus.busGrant) begin
               line_d[req_idx] = (msg_q == MSG_RM) ? SHARED : EXCLUSIVE;
               tag_d[req_idx]  = req_tag;
               fsm_d           = DONE;
               cpu_ready_d     = 1'b1;
               bus_req_d       = 1'b0;
               msg_bus_d       = MSG_NONE;
            end else if (msg_q == MSG_INV && line_d[req_idx] == INVALID) begin
               // Lost our shared copy while waiting: an upgrade is no longer enough.
               msg_d     = MSG_WM;
               msg_bus_d = MSG_WM;
            end
         end
         DONE: fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase

      estado_d = line_d[req_addr_d[INDEX_W-1:0]];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm_q        <= IDLE;
         for (int i = 0; i < LINES; i++) begin
            line_q[i] <= INVALID;
            tag_q[i]  <= '0;
         end
         req_write_q  <= 1'b0;
         req_addr_q   <= '0;
         msg_q        <= MSG_NONE;
         cpu_ready_q  <= 1'b0;
         hit_q        <= 1'b0;
         bus_req_q    <= 1'b0;
         msg_bus_q    <= MSG_NONE;
         bus_addr_q   <= '0;
         write_back_q <= 1'b0;
         estado_q     <= INVALID;
      end else begin
         fsm_q        <= fsm_d;
         line_q       <= line_d;
         tag_q        <= tag_d;
         req_write_q  <= req_write_d;
         req_addr_q   <= req_addr_d;
         msg_q        <= msg_d;
         cpu_ready_q  <= cpu_ready_d;
         hit_q        <= hit_d;
         bus_req_q    <= bus_req_d;
         msg_bus_q    <= msg_bus_d;
         bus_addr_q   <= bus_addr_d;
         write_back_q <= write_back_d;
         estado_q     <= estado_d;
      end
   end

   assign bus.cpuReady    = cpu_ready_q;
   assign bus.hit         = hit_q;
   assign bus.busReq      = bus_req_q;
   assign bus.mensagemBus = msg_bus_q;
   assign bus.busAddr     = bus_addr_q;
   assign bus.writeBack   = write_back_q;
   assign bus.estado      = estado_q;
endmodule

// File: tb/tb_emissor_snooping.sv
// tb/tb_emissor_snooping.sv - directed and randomized checks against a line-state reference model
module tb_emissor_snooping;
   localparam int IW = 2;
   localparam int TW = 4;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   emissor_snooping_if #(.INDEX_W(IW), .TAG_W(TW)) bus ();
   emissor_snooping #(.INDEX_W(IW), .TAG_W(TW)) dut (.clock(clock), .reset(reset), .bus(bus));

   int total = 0;
   int bad   = 0;
   int mstate [4];   // 0 invalid, 1 shared, 2 exclusive
   int mtag   [4];
   int latched;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         mstate[i] = 0;
         mtag[i]   = 0;
      end
      latched = 0;
   endtask

   task automatic model_snoop(input int msg, input int a);
      int idx, tg;
      idx = a % 4;
      tg  = a / 4;
      if (mstate[idx] != 0 && mtag[idx] == tg) begin
         if (msg == 1 || msg == 3) mstate[idx] = 0;
         else if (msg == 2 && mstate[idx] == 2) mstate[idx] = 1;
      end
   endtask

   task automatic do_snoop(input int msg, input int a, input logic g);
      bus.snoopValid = 1'b1;
      bus.snoopMsg   = 3'(msg);
      bus.snoopAddr  = 6'(a);
      bus.busGrant   = g;
      tick();
      bus.snoopValid = 1'b0;
      bus.busGrant   = 1'b0;
      if (!g) model_snoop(msg, a);
      chk("snoop_estado", 32'(bus.estado), 32'(mstate[latched]));
      chk("snoop_idle_busreq", 32'(bus.busReq), 0);
   endtask

   task automatic do_req(input logic w, input int a, input int gdelay,
                         input int snoop_k, input int smsg, input int saddr);
      int idx, tg, msg;
      logic match, is_hit, need_wb;
      idx     = a % 4;
      tg      = a / 4;
      match   = (mstate[idx] != 0) && (mtag[idx] == tg);
      is_hit  = match && (!w || mstate[idx] == 2);
      msg     = (match && w) ? 3 : (w ? 1 : 2);
      need_wb = !match && mstate[idx] == 2;

      bus.cpuValid = 1'b1;
      bus.cpuWrite = w;
      bus.cpuAddr  = 6'(a);
      tick();
      bus.cpuValid = 1'b0;
      latched      = idx;
      chk("e0_busreq", 32'(bus.busReq), 0);
      chk("e0_ready", 32'(bus.cpuReady), 0);
      tick();
      if (is_hit) begin
         chk("hit_ready", 32'(bus.cpuReady), 1);
         chk("hit_flag", 32'(bus.hit), 1);
         chk("hit_busreq", 32'(bus.busReq), 0);
         chk("hit_estado", 32'(bus.estado), 32'(mstate[idx]));
         tick();
         chk("hit_ready_pulse", 32'(bus.cpuReady), 0);
         return;
      end
      chk("miss_ready_e1", 32'(bus.cpuReady), 0);
      if (need_wb) begin
         chk("wb_pulse", 32'(bus.writeBack), 1);
         chk("wb_addr", 32'(bus.busAddr), 32'(mtag[idx] * 4 + idx));
         chk("wb_busreq", 32'(bus.busReq), 0);
         mstate[idx] = 0;
         tick();
         chk("wb_pulse_end", 32'(bus.writeBack), 0);
      end
      chk("req_busreq", 32'(bus.busReq), 1);
      chk("req_msg", 32'(bus.mensagemBus), 32'(msg));
      chk("req_addr", 32'(bus.busAddr), 32'(a));
      for (int k = 0; k < gdelay; k++) begin
         if (k == snoop_k) begin
            bus.snoopValid = 1'b1;
            bus.snoopMsg   = 3'(smsg);
            bus.snoopAddr  = 6'(saddr);
            tick();
            bus.snoopValid = 1'b0;
            model_snoop(smsg, saddr);
            if (msg == 3 && !(mstate[idx] != 0 && mtag[idx] == tg)) msg = 1;
         end else begin
            tick();
         end
         chk("wait_busreq", 32'(bus.busReq), 1);
         chk("wait_msg", 32'(bus.mensagemBus), 32'(msg));
         chk("wait_ready", 32'(bus.cpuReady), 0);
      end
      bus.busGrant = 1'b1;
      tick();
      bus.busGrant = 1'b0;
      mstate[idx] = (msg == 2) ? 1 : 2;
      mtag[idx]   = tg;
      chk("grant_ready", 32'(bus.cpuReady), 1);
      chk("grant_hit", 32'(bus.hit), 0);
      chk("grant_busreq", 32'(bus.busReq), 0);
      chk("grant_msg", 32'(bus.mensagemBus), 0);
      chk("grant_estado", 32'(bus.estado), 32'(mstate[idx]));
      tick();
      chk("done_ready_pulse", 32'(bus.cpuReady), 0);
   endtask

   initial begin
      int w, a, gd, sk;
      reset          = 1'b1;
      bus.cpuValid   = 1'b0;
      bus.cpuWrite   = 1'b0;
      bus.cpuAddr    = '0;
      bus.busGrant   = 1'b0;
      bus.snoopValid = 1'b0;
      bus.snoopMsg   = '0;
      bus.snoopAddr  = '0;
      model_clear();
      tick();
      tick();
      chk("rst_ready", 32'(bus.cpuReady), 0);
      chk("rst_hit", 32'(bus.hit), 0);
      chk("rst_busreq", 32'(bus.busReq), 0);
      chk("rst_wb", 32'(bus.writeBack), 0);
      chk("rst_msg", 32'(bus.mensagemBus), 0);
      chk("rst_addr", 32'(bus.busAddr), 0);
      chk("rst_estado", 32'(bus.estado), 0);
      reset = 1'b0;
      tick();

      do_req(1'b0, 'h05, 3, -1, 0, 0);      // read miss -> SHARED
      do_req(1'b0, 'h05, 0, -1, 0, 0);      // read hit
      do_req(1'b1, 'h05, 1, -1, 0, 0);      // upgrade with INVALIDATE
      do_req(1'b1, 'h05, 0, -1, 0, 0);      // write hit
      do_req(1'b0, 'h15, 2, -1, 0, 0);      // writeback of 0x05 then READ_MISS
      do_req(1'b0, 'h05, 1, -1, 0, 0);      // 0x05 SHARED again
      do_req(1'b1, 'h05, 3, 1, 1, 'h05);    // pending INVALIDATE turns into WRITE_MISS
      chk("conv_estado", 32'(mstate[1]), 2);
      do_snoop(2, 'h05, 1'b0);              // EXCLUSIVE -> SHARED
      do_req(1'b1, 'h05, 0, -1, 0, 0);
      do_snoop(3, 'h25, 1'b0);              // other tag, no change
      do_snoop(1, 'h05, 1'b1);              // own traffic, ignored
      chk("excl_kept", 32'(bus.estado), 2);

      bus.cpuValid = 1'b1;
      bus.cpuWrite = 1'b0;
      bus.cpuAddr  = 6'h0A;
      tick();
      bus.cpuValid = 1'b0;
      tick();
      chk("pre_rst_busreq", 32'(bus.busReq), 1);
      reset = 1'b1;
      #1;
      chk("async_busreq", 32'(bus.busReq), 0);
      chk("async_msg", 32'(bus.mensagemBus), 0);
      tick();
      chk("rst_no_ready", 32'(bus.cpuReady), 0);
      reset = 1'b0;
      model_clear();
      tick();
      do_req(1'b0, 'h05, 1, -1, 0, 0);      // must miss after reset

      for (int n = 0; n < 60; n++) begin
         w  = int'($urandom_range(0, 1));
         a  = int'($urandom_range(0, 15));
         gd = int'($urandom_range(0, 3));
         sk = (gd > 0 && $urandom_range(0, 9) < 3) ? int'($urandom_range(0, gd - 1)) : -1;
         do_req(w[0], a, gd, sk, int'($urandom_range(1, 3)), int'($urandom_range(0, 15)));
         if ($urandom_range(0, 1) == 1)
            do_snoop(int'($urandom_range(1, 3)), int'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
